prio_encoder_seq: RTL and testbench



---
 rtl/prio_enc_pkg.sv | 19 +
 rtl/prio_pick.sv | 31 +++
 rtl/prio_encoder_seq.sv | 130 +++++++++++++
 tb/tb_prio_encoder_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared types, defaults and width helper for the priority encoder
package prio_enc_pkg;

  localparam int PRIO_ENC_DEFAULT_N = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } prio_state_e;

  // Index width for n sources; never below one bit so a 2-input encoder still has an index.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational highest-set-bit finder with one-hot grant
module prio_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] grant_o,
  output logic         any_o
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (req_i[k]) begin
        idx_o = W'(k);
        any_o = 1'b1;
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int k = 0; k < N; k++) begin
      grant_o[k] = any_o && (idx_o == W'(k));
    end
  end

endmodule

// File: rtl/prio_encoder_seq.sv
// rtl/prio_encoder_seq.sv - registered priority encoder with valid/ready handshake
// Define PRIO_ENC_RR_EN for rotating priority; otherwise the highest index always wins.
module prio_encoder_seq
  import prio_enc_pkg::*;
#(
  parameter  int N = PRIO_ENC_DEFAULT_N,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic         any
);

  prio_state_e  state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] grant_q, grant_d;
  logic         any_q, any_d;

  logic [W-1:0] pick_idx;
  logic [N-1:0] pick_grant;
  logic         pick_any;
  logic         in_xfer;
  logic         out_xfer;

  assign in_ready = !rst && ((state_q == ST_EMPTY) || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = (state_q == ST_FULL) && out_ready;

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] rot_req;
  logic [N-1:0] rot_grant;
  logic [W-1:0] rot_idx;
  logic         rot_any;

  // Rotation puts req[ptr] at the top bit so a plain highest-bit pick honours the pointer.
  always_comb begin
    logic [W-1:0] src;
    rot_req = '0;
    for (int k = 0; k < N; k++) begin
      src        = W'((k + int'(ptr_q) + 1) % N);
      rot_req[k] = req[src];
    end
  end

  prio_pick #(.N(N), .W(W)) u_pick (
    .req_i   (rot_req),
    .idx_o   (rot_idx),
    .grant_o (rot_grant),
    .any_o   (rot_any)
  );

  always_comb begin
    logic [W-1:0] src;
    pick_grant = '0;
    for (int k = 0; k < N; k++) begin
      src             = W'((k + int'(ptr_q) + 1) % N);
      pick_grant[src] = rot_grant[k];
    end
    pick_idx = W'((int'(rot_idx) + int'(ptr_q) + 1) % N);
    pick_any = rot_any;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (in_xfer && pick_any) begin
      ptr_d = (pick_idx == '0) ? W'(N - 1) : pick_idx - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  prio_pick #(.N(N), .W(W)) u_pick (
    .req_i   (req),
    .idx_o   (pick_idx),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    any_d   = any_q;
    case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_FULL;
      ST_FULL:  if (out_xfer && !in_xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (in_xfer) begin
      idx_d   = pick_idx;
      grant_d = pick_grant;
      any_d   = pick_any;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      grant_q <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      any_q   <= any_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign idx       = idx_q;
  assign grant     = grant_q;
  assign any       = any_q;

endmodule

// File: tb/tb_prio_encoder_seq.sv
// tb/tb_prio_encoder_seq.sv - self-checking bench for prio_encoder_seq at N=8 and N=5
module tb_prio_encoder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_any;
  logic [7:0] a_req, a_grant;
  logic [2:0] a_idx;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_any;
  logic [4:0] b_req, b_grant;
  logic [2:0] b_idx;

  prio_encoder_seq #(.N(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .req(a_req),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .idx(a_idx), .grant(a_grant), .any(a_any)
  );

  prio_encoder_seq #(.N(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .req(b_req),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .idx(b_idx), .grant(b_grant), .any(b_any)
  );

`ifdef PRIO_ENC_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state per instance (0 = N8, 1 = N5)
  int m_valid[2];
  int m_idx[2];
  int m_any[2];
  int m_ptr[2];

  logic [12:0] a_obs, b_obs;
  assign a_obs = {a_out_valid, a_idx, a_grant, a_any};
  assign b_obs = {b_out_valid, b_idx, 3'b000, b_grant, b_any};

  // Winner by searching from the priority holder downward; -1 when no request.
  function automatic int model_pick(int n, logic [7:0] r, int p);
    int c;
    for (int j = 0; j < n; j++) begin
      c = RR ? (p - j + n) % n : n - 1 - j;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [12:0] exp_vec(int i);
    logic [7:0] g;
    g = '0;
    if (m_any[i] != 0) g[m_idx[i]] = 1'b1;
    return {m_valid[i] != 0, 3'(m_idx[i]), g, m_any[i] != 0};
  endfunction

  function automatic bit exp_ready(int i);
    bit ordy;
    ordy = (i == 0) ? a_out_ready : b_out_ready;
    return !rst && ((m_valid[i] == 0) || ordy);
  endfunction

  task automatic cycle();
    bit         xin[2];
    bit         xout[2];
    logic [7:0] r[2];
    int         w, n;
    for (int i = 0; i < 2; i++) begin
      xin[i]  = ((i == 0) ? a_in_valid : b_in_valid) && exp_ready(i);
      xout[i] = (m_valid[i] != 0) && ((i == 0) ? a_out_ready : b_out_ready);
      r[i]    = (i == 0) ? a_req : {3'b000, b_req};
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n = (i == 0) ? 8 : 5;
      if (rst) begin
        m_valid[i] = 0; m_idx[i] = 0; m_any[i] = 0; m_ptr[i] = n - 1;
      end else if (xin[i]) begin
        w = model_pick(n, r[i], m_ptr[i]);
        m_valid[i] = 1;
        m_any[i]   = (w >= 0);
        m_idx[i]   = (w >= 0) ? w : 0;
        if (w >= 0) m_ptr[i] = (w == 0) ? n - 1 : w - 1;
      end else if (xout[i]) begin
        m_valid[i] = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 0; a_out_ready = 1; a_req = '0;
    b_in_valid = 0; b_out_ready = 1; b_req = '0;
    cycle();
    cycle();
    n_cmp++;
    if (a_obs !== 13'd0) begin n_bad++; $display("FAIL reset_outputs_a: got %h want 0", a_obs); end
    n_cmp++;
    if (b_obs !== 13'd0) begin n_bad++; $display("FAIL reset_outputs_b: got %h want 0", b_obs); end
    n_cmp++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready: got %b%b want 00", a_in_ready, b_in_ready);
    end
    rst = 1'b0;
    cycle();
    n_cmp++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_in_ready: got %b%b want 11", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_fixed();
    a_req = 8'hA0; a_in_valid = 1;
    cycle();
    n_cmp++;
    if (a_obs !== {1'b1, 3'd7, 8'h80, 1'b1}) begin
      n_bad++; $display("FAIL fixed_a0: got %h want %h", a_obs, {1'b1, 3'd7, 8'h80, 1'b1});
    end
    a_req = 8'h00;
    cycle();
    n_cmp++;
    if (a_obs !== {1'b1, 3'd0, 8'h00, 1'b0}) begin
      n_bad++; $display("FAIL zero_req: got %h want %h", a_obs, {1'b1, 3'd0, 8'h00, 1'b0});
    end
    a_in_valid = 0;
    cycle();
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_obs !== exp_vec(0)) begin
      n_bad++; $display("FAIL drain_empty: got %h want %h", a_obs, exp_vec(0));
    end
  endtask

  task automatic test_backpressure();
    a_out_ready = 0; a_req = 8'h04; a_in_valid = 1;
    cycle();
    a_req = 8'h10;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_idx !== 3'd2 || a_grant !== 8'h04) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b idx=%0d g=%h want rdy=0 v=1 idx=2 g=04",
                 k, a_in_ready, a_out_valid, a_idx, a_grant);
      end
      cycle();
    end
    a_out_ready = 1;
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", a_in_ready); end
    cycle();
    a_in_valid = 0;
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_idx !== 3'd4 || a_grant !== 8'h10 || a_obs !== exp_vec(0)) begin
      n_bad++; $display("FAIL release_next: got v=%b idx=%0d g=%h want v=1 idx=4 g=10", a_out_valid, a_idx, a_grant);
    end
    cycle();
  endtask

  task automatic test_round_robin();
`ifdef PRIO_ENC_RR_EN
    int exp_seq[6] = '{7, 6, 5, 4, 0, 7};
    rst = 1; cycle(); rst = 0; cycle();
    a_out_ready = 1; a_in_valid = 1;
    for (int k = 0; k < 6; k++) begin
      a_req = (k < 4) ? 8'hFF : 8'h81;
      cycle();
      n_cmp++;
      if (a_idx !== 3'(exp_seq[k]) || a_any !== 1'b1) begin
        n_bad++; $display("FAIL rr_seq[%0d]: got idx=%0d any=%b want idx=%0d any=1", k, a_idx, a_any, exp_seq[k]);
      end
    end
    a_in_valid = 0;
    cycle();
`endif
  endtask

  task automatic test_reset_mid_stall();
    a_out_ready = 0; a_req = 8'h22; a_in_valid = 1;
    cycle();
    a_in_valid = 0;
    n_cmp++;
    if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_setup: got %b want 1", a_out_valid); end
    rst = 1;
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_comb: got %b want 0", a_in_ready); end
    cycle();
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_grant !== 8'h00 || a_in_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_stall: got v=%b g=%h rdy=%b want 0 00 0", a_out_valid, a_grant, a_in_ready);
    end
    rst = 0; a_out_ready = 1; a_req = 8'hFF; a_in_valid = 1;
    cycle();
    a_in_valid = 0;
    n_cmp++;
    if (a_idx !== 3'd7 || a_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL ptr_after_rst: got idx=%0d v=%b want idx=7 v=1", a_idx, a_out_valid);
    end
    cycle();
  endtask

  task automatic test_n5_back_to_back();
    b_out_ready = 1; b_req = 5'b10010; b_in_valid = 1;
    cycle();
    n_cmp++;
    if (b_idx !== 3'd4 || b_grant !== 5'b10000 || b_any !== 1'b1 || b_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL n5_basic: got idx=%0d g=%b any=%b want idx=4 g=10000 any=1", b_idx, b_grant, b_any);
    end
    for (int k = 0; k < 20; k++) begin
      b_req = 5'($urandom);
      cycle();
      n_cmp++;
      if (b_out_valid !== 1'b1 || b_in_ready !== 1'b1 || b_obs !== exp_vec(1)) begin
        n_bad++; $display("FAIL n5_b2b[%0d]: got %h rdy=%b want %h rdy=1", k, b_obs, b_in_ready, exp_vec(1));
      end
    end
    b_in_valid = 0;
    cycle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst         = ($urandom_range(0, 59) == 0);
      a_in_valid  = $urandom_range(0, 3) != 0;
      a_out_ready = $urandom_range(0, 9) < 6;
      b_in_valid  = $urandom_range(0, 3) != 0;
      b_out_ready = $urandom_range(0, 9) < 7;
      case ($urandom_range(0, 3))
        0:       a_req = 8'h00;
        1:       a_req = 8'h01 << $urandom_range(0, 7);
        default: a_req = 8'($urandom);
      endcase
      b_req = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      #1;
      n_cmp++;
      if (a_in_ready !== exp_ready(0) || b_in_ready !== exp_ready(1)) begin
        n_bad++; $display("FAIL rand_ready[%0d]: got %b%b want %b%b", k, a_in_ready, b_in_ready, exp_ready(0), exp_ready(1));
      end
      cycle();
      n_cmp++;
      if (a_obs !== exp_vec(0)) begin n_bad++; $display("FAIL rand_a[%0d]: got %h want %h", k, a_obs, exp_vec(0)); end
      n_cmp++;
      if (b_obs !== exp_vec(1)) begin n_bad++; $display("FAIL rand_b[%0d]: got %h want %h", k, b_obs, exp_vec(1)); end
    end
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_idx[i] = 0; m_any[i] = 0; m_ptr[i] = (i == 0) ? 7 : 4;
    end
    test_reset();
    test_fixed();
    test_backpressure();
    test_round_robin();
    test_reset_mid_stall();
    test_n5_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
